// File: rtl/prim_fifo_async_wr_packer.sv
// Write-domain packer in front of prim_fifo_async. It gathers Ratio narrow beats into
// one wide word tagged {last, lane count, data} and drives the FIFO write port.

module prim_fifo_async_wr_packer_lane #(
  parameter int InW = 8
) (
  input  logic           clk_wr_i,
  input  logic           rst_wr_ni,
  input  logic           we,
  input  logic           clr,
  input  logic [InW-1:0] din,
  output logic [InW-1:0] q_nxt
);
  logic [InW-1:0] q;

  always_ff @(posedge clk_wr_i or negedge rst_wr_ni) begin
    if (!rst_wr_ni)  q <= '0;
    else if (clr)    q <= '0;
    else if (we)     q <= din;
  end

  // A beat arriving in the cycle its word closes must still reach the output register.
  assign q_nxt = we ? din : q;
endmodule

module prim_fifo_async_wr_packer #(
  parameter  int InW   = 8,
  parameter  int Ratio = 4,
  localparam int CntW  = $clog2(Ratio + 1),
  localparam int OutW  = InW * Ratio + CntW + 1
) (
  input  logic            clk_wr_i,
  input  logic            rst_wr_ni,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [InW-1:0]  in_data_i,
  input  logic            in_last_i,
  input  logic            flush_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [OutW-1:0] out_data_o,
  output logic [CntW-1:0] fill_o,
  output logic [15:0]     pkt_cnt_o
);
  if (Ratio < 2) begin : gen_ratio_chk
    $error("prim_fifo_async_wr_packer: Ratio must be >= 2");
  end

  logic                       out_valid_q;
  logic [OutW-1:0]            out_data_q;
  logic [CntW-1:0]            fill_q;
  logic [15:0]                pkt_cnt_q;
  logic                       accept, close_beat, close_flush, close, word_last;
  logic [CntW-1:0]            word_cnt;
  logic [Ratio-1:0][InW-1:0]  acc_nxt;

  assign in_ready_o  = !out_valid_q | out_ready_i;
  assign accept      = in_valid_i & in_ready_o;
  assign close_beat  = accept & ((fill_q == CntW'(Ratio - 1)) | in_last_i | flush_i);
  // Flush-only close needs the output slot, otherwise it is simply dropped.
  assign close_flush = flush_i & !accept & in_ready_o & (fill_q != '0);
  assign close       = close_beat | close_flush;
  assign word_last   = close_beat & in_last_i;
  assign word_cnt    = accept ? fill_q + CntW'(1) : fill_q;

  for (genvar i = 0; i < Ratio; i++) begin : gen_lane
    prim_fifo_async_wr_packer_lane #(.InW(InW)) u_lane (
      .clk_wr_i  (clk_wr_i),
      .rst_wr_ni (rst_wr_ni),
      .we        (accept & (fill_q == CntW'(i))),
      .clr       (close),
      .din       (in_data_i),
      .q_nxt     (acc_nxt[i])
    );
  end

  always_ff @(posedge clk_wr_i or negedge rst_wr_ni) begin
    if (!rst_wr_ni) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      fill_q      <= '0;
      pkt_cnt_q   <= '0;
    end else begin
      if (close) begin
        out_valid_q <= 1'b1;
        out_data_q  <= {word_last, word_cnt, acc_nxt};
      end else if (out_valid_q && out_ready_i) begin
        out_valid_q <= 1'b0;
      end
      if (close)       fill_q <= '0;
      else if (accept) fill_q <= fill_q + CntW'(1);
      if (close && word_last) pkt_cnt_q <= pkt_cnt_q + 16'd1;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign fill_o      = fill_q;
  assign pkt_cnt_o   = pkt_cnt_q;
endmodule

// File: tb/tb_prim_fifo_async_wr_packer.sv
// Directed and random bench for prim_fifo_async_wr_packer; a byte-queue model
// builds the expected packed words and every cycle is checked against it.

module tb_prim_fifo_async_wr_packer;
  localparam int IN_W  = 8;
  localparam int RATIO = 4;
  localparam int CNT_W = 3;
  localparam int OUT_W = 36;

  logic             clk_wr_i = 1'b0;
  logic             rst_wr_ni;
  logic             in_valid_i, in_ready_o, in_last_i, flush_i;
  logic [IN_W-1:0]  in_data_i;
  logic             out_valid_o, out_ready_i;
  logic [OUT_W-1:0] out_data_o;
  logic [CNT_W-1:0] fill_o;
  logic [15:0]      pkt_cnt_o;

  int checks = 0;
  int errors = 0;

  logic [7:0]       bq[$];   // beats gathered for the word under construction
  logic [OUT_W-1:0] sb[$];   // words loaded but not yet drained
  logic [15:0]      mpkt;
  logic [OUT_W-1:0] saved;

  always #5 clk_wr_i = ~clk_wr_i;

  prim_fifo_async_wr_packer #(.InW(IN_W), .Ratio(RATIO)) dut (
    .clk_wr_i    (clk_wr_i),
    .rst_wr_ni   (rst_wr_ni),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .in_last_i   (in_last_i),
    .flush_i     (flush_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .fill_o      (fill_o),
    .pkt_cnt_o   (pkt_cnt_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic close_word(input bit last);
    logic [31:0] data;
    data = '0;
    foreach (bq[i]) data[i*8 +: 8] = bq[i];
    sb.push_back({last, 3'(bq.size()), data});
    bq.delete();
    if (last) mpkt = mpkt + 16'd1;
  endtask

  // One clock: drive at negedge, check against the model, then let the edge happen.
  task automatic cyc(input bit v, input logic [7:0] d, input bit l, input bit f, input bit r);
    bit exp_rdy, acc;
    @(negedge clk_wr_i);
    in_valid_i = v; in_data_i = d; in_last_i = l; flush_i = f; out_ready_i = r;
    #1;
    exp_rdy = (sb.size() == 0) || r;
    chk("in_ready", 64'(in_ready_o), 64'(exp_rdy));
    chk("out_valid", 64'(out_valid_o), 64'(sb.size() != 0));
    chk("fill", 64'(fill_o), 64'(bq.size()));
    chk("pkt_cnt", 64'(pkt_cnt_o), 64'(mpkt));
    if (sb.size() != 0) chk("out_data", 64'(out_data_o), 64'(sb[0]));
    acc = v && exp_rdy;
    if (sb.size() != 0 && r) void'(sb.pop_front());
    if (acc) begin
      bq.push_back(d);
      if (bq.size() == RATIO || l || f) close_word(l);
    end else if (f && bq.size() > 0 && exp_rdy) begin
      close_word(1'b0);
    end
    @(posedge clk_wr_i);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk_wr_i);
    in_valid_i = 0; in_last_i = 0; flush_i = 0; out_ready_i = 0; in_data_i = '0;
    rst_wr_ni = 0;
    #1;
    chk("rst_out_valid", 64'(out_valid_o), 64'd0);
    chk("rst_out_data", 64'(out_data_o), 64'd0);
    chk("rst_fill", 64'(fill_o), 64'd0);
    chk("rst_pkt_cnt", 64'(pkt_cnt_o), 64'd0);
    bq.delete(); sb.delete(); mpkt = '0;
    @(negedge clk_wr_i);
    rst_wr_ni = 1;
    @(posedge clk_wr_i);
    #1;
  endtask

  initial begin
    rst_wr_ni = 0; in_valid_i = 0; in_last_i = 0; flush_i = 0; out_ready_i = 0;
    in_data_i = '0; mpkt = '0;
    repeat (2) @(posedge clk_wr_i);
    do_reset();

    // Full word of four beats
    cyc(1, 8'h11, 0, 0, 1); cyc(1, 8'h22, 0, 0, 1);
    cyc(1, 8'h33, 0, 0, 1); cyc(1, 8'h44, 0, 0, 1);
    chk("full_word_valid", 64'(out_valid_o), 64'd1);
    chk("full_word", 64'(out_data_o), 64'h444332211);

    // Short packet closed by last
    cyc(1, 8'h11, 0, 0, 1); cyc(1, 8'h22, 1, 0, 1);
    chk("last_word", 64'(out_data_o), 64'hA00002211);
    chk("last_pkt_cnt", 64'(pkt_cnt_o), 64'd1);

    // Backpressure: word pending, further beats refused
    cyc(1, 8'h05, 0, 0, 1); cyc(1, 8'h06, 0, 0, 1); cyc(1, 8'h07, 0, 0, 1);
    cyc(1, 8'h08, 0, 0, 0);
    saved = out_data_o;
    chk("bp_word", 64'(saved), 64'h408070605);
    for (int i = 0; i < 4; i++) cyc(1, 8'(8'h09 + i), 0, 0, 0);
    chk("bp_stable", 64'(out_data_o), 64'(saved));
    chk("bp_fill", 64'(fill_o), 64'd0);
    for (int i = 0; i < 4; i++) cyc(1, 8'(8'h09 + i), 0, 0, 1);
    chk("bp_resume_valid", 64'(out_valid_o), 64'd1);

    // Flush of a partial word, then a flush with nothing held
    cyc(1, 8'h11, 0, 0, 1); cyc(1, 8'h22, 0, 0, 1); cyc(1, 8'h33, 0, 0, 1);
    cyc(0, 8'h00, 0, 0, 1);
    cyc(0, 8'h00, 0, 1, 1);
    chk("flush_word", 64'(out_data_o), 64'h300332211);
    chk("flush_fill", 64'(fill_o), 64'd0);
    cyc(0, 8'h00, 0, 1, 1);
    chk("flush_empty", 64'(out_valid_o), 64'd0);

    // Reset with a pending word, then with a partial word
    cyc(1, 8'h01, 0, 0, 0); cyc(1, 8'h02, 0, 0, 0);
    cyc(1, 8'h03, 0, 0, 0); cyc(1, 8'h04, 0, 0, 0);
    chk("pre_rst_valid", 64'(out_valid_o), 64'd1);
    do_reset();
    cyc(1, 8'h01, 0, 0, 1); cyc(1, 8'h02, 0, 0, 1);
    chk("pre_rst_fill", 64'(fill_o), 64'd2);
    do_reset();
    cyc(1, 8'hA1, 0, 0, 1); cyc(1, 8'hA2, 0, 0, 1);
    cyc(1, 8'hA3, 0, 0, 1); cyc(1, 8'hA4, 0, 0, 1);
    chk("post_rst_word", 64'(out_data_o), 64'h4A4A3A2A1);

    // Packet counter wrap, back-to-back single-beat packets
    do_reset();
    for (int i = 0; i < 65537; i++) cyc(1, 8'(i), 1, 0, 1);
    chk("pkt_wrap", 64'(pkt_cnt_o), 64'd1);

    // Random valid/ready/last/flush stream
    for (int i = 0; i < 1500; i++)
      cyc(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 7) == 0),
          1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 9) < 7));
    for (int i = 0; i < 3; i++) cyc(0, 8'h00, 0, 0, 1);
    chk("final_idle", 64'(out_valid_o), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
